dma_arbiter: RTL and testbench

Two-requester DMA arbiter placed in front of the openMSP430 DMA port, upstream of the key-memory access monitor. It shares the single DMA interface between two masters with round-robin fairness and a bounded burst allowance. It rejects any transfer aimed at KMEM before it reaches the bus, so a misbehaving master gets an error response instead of forcing a monitor-triggered reset. It also bounds every transfer with a ready timeout.

---
 rtl/dma_arb_pkg.sv | 36 +++
 rtl/kmem_window_chk.sv | 31 +++
 rtl/dma_arbiter.sv | 195 +++++++++++++++++++
 tb/tb_dma_arbiter.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dma_arb_pkg.sv
// -----------------------------------------------------------------------------
// dma_arb_pkg
// Shared types and default constants for the two-requester DMA arbiter that
// sits in front of the openMSP430 DMA port.
//   state_t  : arbiter FSM states (IDLE, XFER, ERR)
//   owner_t  : requester id (0 or 1)
//   *_DEF    : default KMEM window, burst allowance and ready timeout
// -----------------------------------------------------------------------------
package dma_arb_pkg;

   localparam int ADDR_W  = 16;
   localparam int DATA_W  = 16;
   localparam int WE_W    = 2;
   localparam int BURST_W = 4;
   localparam int WAIT_W  = 8;

   // Arbiter FSM states
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      XFER = 2'd1,
      ERR  = 2'd2
   } state_t;

   // Requester id
   typedef logic owner_t;

   localparam owner_t OWNER0 = 1'b0;
   localparam owner_t OWNER1 = 1'b1;

   // Protected key-memory window and arbitration defaults
   localparam logic [ADDR_W-1:0]  KMEM_BASE_DEF = 16'hFEFE;
   localparam logic [ADDR_W-1:0]  KMEM_SIZE_DEF = 16'h0040;
   localparam logic [BURST_W-1:0] MAX_BURST_DEF = 4'd8;
   localparam logic [WAIT_W-1:0]  TIMEOUT_DEF   = 8'd255;

endpackage

// File: rtl/kmem_window_chk.sv
// -----------------------------------------------------------------------------
// kmem_window_chk
// Purely combinational check of whether a byte address falls inside the
// protected key-memory window [i_base, i_base + i_size). Shared with the other
// bus monitors so every block agrees on the window boundaries.
//   i_addr      : byte address under test
//   i_base      : first protected byte address
//   i_size      : window size in bytes
//   o_in_window : 1 when i_addr lies inside the window
// -----------------------------------------------------------------------------
module kmem_window_chk
   import dma_arb_pkg::*;
(
   input  logic [ADDR_W-1:0] i_addr,
   input  logic [ADDR_W-1:0] i_base,
   input  logic [ADDR_W-1:0] i_size,
   output logic              o_in_window
);

   logic [ADDR_W:0] w_addr_ext;
   logic [ADDR_W:0] w_lo;
   logic [ADDR_W:0] w_hi;

   // The upper bound is formed one bit wider so a window that runs past
   // 16'hFFFF does not wrap around to low addresses.
   assign w_addr_ext  = {1'b0, i_addr};
   assign w_lo        = {1'b0, i_base};
   assign w_hi        = {1'b0, i_base} + {1'b0, i_size};
   assign o_in_window = (w_addr_ext >= w_lo) && (w_addr_ext < w_hi);

endmodule

// File: rtl/dma_arbiter.sv
// -----------------------------------------------------------------------------
// dma_arbiter
// Shares the single openMSP430 DMA port between two masters with round-robin
// fairness and a bounded burst allowance. Transfers aimed at the key-memory
// window are answered with an error pulse and never reach the bus; every bus
// transfer is bounded by a ready timeout.
// Ports:
//   i_clk, i_reset_n          : clock, asynchronous active-low reset
//   i_req0/1                  : transfer request, held with attributes until
//                               gnt or err
//   i_addr0/1, i_we0/1,
//   i_wdata0/1                : transfer attributes (we = 0 means read)
//   o_gnt0/1                  : transfer completed, one-cycle pulse
//   o_err0/1                  : transfer rejected or timed out, one-cycle pulse
//   o_rdata                   : read data, valid while a gnt pulse is high
//   i_lock                    : blocks new grants, in-flight transfer finishes
//   o_dma_en, o_dma_addr,
//   o_dma_we, o_dma_din       : DMA request to the core
//   i_dma_dout, i_dma_ready   : DMA response from the core
// -----------------------------------------------------------------------------
module dma_arbiter
   import dma_arb_pkg::*;
#(
   parameter logic [ADDR_W-1:0]  KMEM_BASE = KMEM_BASE_DEF,
   parameter logic [ADDR_W-1:0]  KMEM_SIZE = KMEM_SIZE_DEF,
   parameter logic [BURST_W-1:0] MAX_BURST = MAX_BURST_DEF,
   parameter logic [WAIT_W-1:0]  TIMEOUT   = TIMEOUT_DEF
)(
   input  logic              i_clk,
   input  logic              i_reset_n,
   input  logic              i_req0,
   input  logic              i_req1,
   input  logic [ADDR_W-1:0] i_addr0,
   input  logic [ADDR_W-1:0] i_addr1,
   input  logic [WE_W-1:0]   i_we0,
   input  logic [WE_W-1:0]   i_we1,
   input  logic [DATA_W-1:0] i_wdata0,
   input  logic [DATA_W-1:0] i_wdata1,
   output logic              o_gnt0,
   output logic              o_gnt1,
   output logic              o_err0,
   output logic              o_err1,
   output logic [DATA_W-1:0] o_rdata,
   input  logic              i_lock,
   output logic              o_dma_en,
   output logic [ADDR_W-1:0] o_dma_addr,
   output logic [WE_W-1:0]   o_dma_we,
   output logic [DATA_W-1:0] o_dma_din,
   input  logic [DATA_W-1:0] i_dma_dout,
   input  logic              i_dma_ready
);

   state_t              r_state;
   state_t              w_state_nxt;
   owner_t              r_owner;
   owner_t              r_last_owner;
   logic [BURST_W-1:0]  r_burst_cnt;
   logic [BURST_W-1:0]  w_burst_nxt;
   logic [WAIT_W-1:0]   r_wait_cnt;
   logic [ADDR_W-1:0]   r_addr;
   logic [WE_W-1:0]     r_we;
   logic [DATA_W-1:0]   r_wdata;

   logic [1:0]          w_req;
   owner_t              w_other;
   owner_t              w_sel;
   logic                w_keep;
   logic                w_start;
   logic                w_timeout;
   logic                w_sel_in_kmem;
   logic [ADDR_W-1:0]   w_sel_addr;
   logic [WE_W-1:0]     w_sel_we;
   logic [DATA_W-1:0]   w_sel_wdata;

   assign w_req     = {i_req1, i_req0};
   assign w_other   = ~r_last_owner;
   assign w_start   = (r_state == IDLE) && !i_lock && (|w_req);
   assign w_timeout = (r_wait_cnt == TIMEOUT);

   // Owner selection. A burst count of zero means nobody has been granted
   // since reset, so the last-owner default of 1 only acts as a tie-breaker
   // that hands the first contested grant to requester 0.
   always_comb begin
      w_keep = (r_burst_cnt != '0) && (r_burst_cnt < MAX_BURST) && w_req[r_last_owner];
      if (w_keep) begin
         w_sel = r_last_owner;
      end else if (w_req[w_other]) begin
         w_sel = w_other;
      end else begin
         w_sel = r_last_owner;
      end
   end

   // Burst accounting. When the owner has used its allowance but the other
   // requester is idle, the owner keeps going and the count saturates.
   always_comb begin
      if (w_sel != r_last_owner) begin
         w_burst_nxt = BURST_W'(1);
      end else if (r_burst_cnt < MAX_BURST) begin
         w_burst_nxt = r_burst_cnt + BURST_W'(1);
      end else begin
         w_burst_nxt = r_burst_cnt;
      end
   end

   assign w_sel_addr  = (w_sel == OWNER1) ? i_addr1  : i_addr0;
   assign w_sel_we    = (w_sel == OWNER1) ? i_we1    : i_we0;
   assign w_sel_wdata = (w_sel == OWNER1) ? i_wdata1 : i_wdata0;

   kmem_window_chk u_kmem_chk (
      .i_addr      (w_sel_addr),
      .i_base      (KMEM_BASE),
      .i_size      (KMEM_SIZE),
      .o_in_window (w_sel_in_kmem)
   );

   // State, ownership and latched transfer attributes. All DMA outputs are
   // decoded from these registers, so the asynchronous reset silences the bus
   // immediately without issuing gnt or err for an aborted transfer.
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         r_state      <= IDLE;
         r_owner      <= OWNER0;
         r_last_owner <= OWNER1;
         r_burst_cnt  <= '0;
         r_wait_cnt   <= '0;
         r_addr       <= '0;
         r_we         <= '0;
         r_wdata      <= '0;
      end else begin
         r_state <= w_state_nxt;
         if (w_start) begin
            r_owner      <= w_sel;
            r_last_owner <= w_sel;
            r_burst_cnt  <= w_burst_nxt;
            r_addr       <= w_sel_addr;
            r_we         <= w_sel_we;
            r_wdata      <= w_sel_wdata;
            r_wait_cnt   <= '0;
         end else if (r_state == XFER) begin
            r_wait_cnt <= r_wait_cnt + WAIT_W'(1);
         end
      end
   end

   // Next-state and output decode. Completion and error pulses are combinational
   // so gnt lines up with dma_ready and rdata in the same cycle. A timed-out
   // transfer drops dma_en in the cycle the error is reported.
   always_comb begin
      w_state_nxt = r_state;
      o_dma_en    = 1'b0;
      o_dma_addr  = '0;
      o_dma_we    = '0;
      o_dma_din   = '0;
      o_gnt0      = 1'b0;
      o_gnt1      = 1'b0;
      o_err0      = 1'b0;
      o_err1      = 1'b0;
      o_rdata     = '0;
      case (r_state)
         IDLE: begin
            if (w_start) begin
               w_state_nxt = w_sel_in_kmem ? ERR : XFER;
            end
         end
         XFER: begin
            if (w_timeout) begin
               o_err0      = (r_owner == OWNER0);
               o_err1      = (r_owner == OWNER1);
               w_state_nxt = IDLE;
            end else begin
               o_dma_en   = 1'b1;
               o_dma_addr = r_addr;
               o_dma_we   = r_we;
               o_dma_din  = r_wdata;
               if (i_dma_ready) begin
                  o_gnt0      = (r_owner == OWNER0);
                  o_gnt1      = (r_owner == OWNER1);
                  o_rdata     = i_dma_dout;
                  w_state_nxt = IDLE;
               end
            end
         end
         ERR: begin
            o_err0      = (r_owner == OWNER0);
            o_err1      = (r_owner == OWNER1);
            w_state_nxt = IDLE;
         end
         default: begin
            w_state_nxt = IDLE;
         end
      endcase
   end

endmodule

// File: tb/tb_dma_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dma_arbiter
// Self-checking bench for dma_arbiter. Requests are issued by bumping per-
// channel issue counters; each expected response (owner, gnt/err, address) is
// queued when stimulus is driven and compared when the DUT pulses gnt or err.
// The core side returns dma_dout = dma_addr ^ 16'h5A5A.
// -----------------------------------------------------------------------------
module tb_dma_arbiter;
   import dma_arb_pkg::*;

   typedef struct {
      logic [3:0]  flags;
      logic [15:0] addr;
   } expect_t;

   logic        clk = 1'b0;
   logic        resetN;
   logic        req0, req1;
   logic [15:0] addr0, addr1;
   logic [1:0]  we0, we1;
   logic [15:0] wdata0, wdata1;
   logic        gnt0, gnt1, err0, err1;
   logic [15:0] rdata;
   logic        lock;
   logic        dmaEn;
   logic [15:0] dmaAddr;
   logic [1:0]  dmaWe;
   logic [15:0] dmaDin;
   logic [15:0] dmaDout;
   logic        dmaReady;

   int          issued0 = 0, issued1 = 0;
   int          done0 = 0, done1 = 0;
   int          checkCount = 0;
   int          failCount = 0;
   expect_t     expQ[$];
   expect_t     monExp;
   logic [3:0]  monFlags;

   // Free-running clock, 10 time units per cycle
   always #5 clk = ~clk;

   assign dmaDout = dmaAddr ^ 16'h5A5A;
   assign req0    = (issued0 != done0);
   assign req1    = (issued1 != done1);

   dma_arbiter dut (
      .i_clk       (clk),
      .i_reset_n   (resetN),
      .i_req0      (req0),
      .i_req1      (req1),
      .i_addr0     (addr0),
      .i_addr1     (addr1),
      .i_we0       (we0),
      .i_we1       (we1),
      .i_wdata0    (wdata0),
      .i_wdata1    (wdata1),
      .o_gnt0      (gnt0),
      .o_gnt1      (gnt1),
      .o_err0      (err0),
      .o_err1      (err1),
      .o_rdata     (rdata),
      .i_lock      (lock),
      .o_dma_en    (dmaEn),
      .o_dma_addr  (dmaAddr),
      .o_dma_we    (dmaWe),
      .o_dma_din   (dmaDin),
      .i_dma_dout  (dmaDout),
      .i_dma_ready (dmaReady)
   );

   // Single comparison point: counts every check and reports mismatches
   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checkCount++;
      if (obs !== exp) begin
         failCount++;
         $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference window model, computed in plain integer arithmetic
   function automatic logic inKmem(input logic [15:0] a);
      int v;
      v = int'(a);
      return (v >= 32'hFEFE) && (v < 32'hFEFE + 32'h40);
   endfunction

   // Queue one expected response: flags are {err1, err0, gnt1, gnt0}
   task automatic pushExpect(input int ch, input logic [15:0] a, input logic isErr);
      expect_t e;
      e.addr = a;
      if (isErr) e.flags = (ch == 1) ? 4'b1000 : 4'b0100;
      else       e.flags = (ch == 1) ? 4'b0010 : 4'b0001;
      expQ.push_back(e);
   endtask

   // Drive attributes and raise a channel's request for n transfers
   task automatic applyStimulus(input int ch, input int n, input logic [15:0] a,
                                input logic [1:0] we, input logic [15:0] wd);
      if (ch == 1) begin
         addr1 = a; we1 = we; wdata1 = wd; issued1 = issued1 + n;
      end else begin
         addr0 = a; we0 = we; wdata0 = wd; issued0 = issued0 + n;
      end
   endtask

   // Wait (bounded) until all expected responses arrived and no request is
   // pending, then leave one idle cycle so the next test starts from IDLE
   task automatic waitDrain(input string tag, input int budget);
      for (int i = 0; i < budget && (expQ.size() != 0 || req0 || req1); i++) @(negedge clk);
      checkOutput({tag, "_queue"}, expQ.size(), 0);
      checkOutput({tag, "_pending"}, {30'd0, req1, req0}, 0);
      @(negedge clk);
      @(negedge clk);
   endtask

   // Response monitor: compares each gnt/err pulse with the scoreboard head
   always @(posedge clk) begin
      #1;
      monFlags = {err1, err0, gnt1, gnt0};
      if (monFlags != 4'b0000) begin
         if (expQ.size() == 0) begin
            checkOutput("unexpectedResp", monFlags, 4'b0000);
         end else begin
            monExp = expQ.pop_front();
            checkOutput("respFlags", monFlags, monExp.flags);
            if (monExp.flags[1:0] != 2'b00) begin
               checkOutput("respRdata", rdata, monExp.addr ^ 16'h5A5A);
               checkOutput("respAddr", dmaAddr, monExp.addr);
            end
         end
         if (gnt0 || err0) done0++;
         if (gnt1 || err1) done1++;
      end
   end

   // Watchdog so the bench can never hang
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      logic [15:0] bound [6];
      int          enCount;
      logic        errSeen;

      bound = '{16'hFEFD, 16'hFEFE, 16'hFF3D, 16'hFF3E, 16'hFFFF, 16'h0000};
      resetN = 1'b0; lock = 1'b0; dmaReady = 1'b1;
      addr0 = '0; addr1 = '0; we0 = '0; we1 = '0; wdata0 = '0; wdata1 = '0;

      // Reset state
      repeat (2) @(negedge clk);
      checkOutput("rstDmaEn", dmaEn, 0);
      checkOutput("rstDmaBus", {dmaAddr, dmaDin}, 0);
      checkOutput("rstDmaWe", dmaWe, 0);
      checkOutput("rstPulses", {err1, err0, gnt1, gnt0}, 0);
      checkOutput("rstRdata", rdata, 0);
      resetN = 1'b1;
      @(negedge clk);

      // Single read: dma_en one cycle, gnt0 in the same cycle
      applyStimulus(0, 1, 16'h0200, 2'b00, 16'h0000);
      pushExpect(0, 16'h0200, 1'b0);
      @(posedge clk); #1;
      checkOutput("rdEnRise", dmaEn, 1);
      checkOutput("rdAddr", dmaAddr, 16'h0200);
      checkOutput("rdGnt0", gnt0, 1);
      checkOutput("rdNoErr", err0, 0);
      @(posedge clk); #1;
      checkOutput("rdEnOneCycle", dmaEn, 0);
      waitDrain("read", 20);

      // Write: attributes reach the DMA port
      applyStimulus(0, 1, 16'h0600, 2'b11, 16'hBEEF);
      pushExpect(0, 16'h0600, 1'b0);
      @(posedge clk); #1;
      checkOutput("wrWe", dmaWe, 2'b11);
      checkOutput("wrDin", dmaDin, 16'hBEEF);
      waitDrain("write", 20);

      // KMEM rejection on requester 1
      applyStimulus(1, 1, 16'hFF00, 2'b00, 16'h0000);
      pushExpect(1, 16'hFF00, 1'b1);
      @(posedge clk); #1;
      checkOutput("kmemErr1", err1, 1);
      checkOutput("kmemNoEn", dmaEn, 0);
      @(posedge clk); #1;
      checkOutput("kmemErrPulse", err1, 0);
      checkOutput("kmemNoEn2", dmaEn, 0);
      waitDrain("kmem", 20);

      // The rejection counted as a grant for 1, so 1 keeps priority
      applyStimulus(0, 1, 16'h0700, 2'b00, 16'h0000);
      applyStimulus(1, 1, 16'h0800, 2'b00, 16'h0000);
      pushExpect(1, 16'h0800, 1'b0);
      pushExpect(0, 16'h0700, 1'b0);
      waitDrain("fairPtr", 40);

      // Window boundaries
      foreach (bound[i]) begin
         applyStimulus(0, 1, bound[i], 2'b00, 16'h0000);
         pushExpect(0, bound[i], inKmem(bound[i]));
         waitDrain("bound", 20);
      end

      // Continuous contention after reset: 8 grants each, alternating
      @(negedge clk) resetN = 1'b0;
      @(negedge clk) resetN = 1'b1;
      @(negedge clk);
      applyStimulus(0, 16, 16'h1000, 2'b00, 16'h0000);
      applyStimulus(1, 16, 16'h2000, 2'b00, 16'h0000);
      for (int k = 0; k < 32; k++) begin
         if (((k / 8) % 2) == 0) pushExpect(0, 16'h1000, 1'b0);
         else                    pushExpect(1, 16'h2000, 1'b0);
      end
      waitDrain("burst", 200);

      // Ready timeout: 255 cycles with dma_en, then err0 with dma_en low
      dmaReady = 1'b0;
      applyStimulus(0, 1, 16'h0300, 2'b00, 16'h0000);
      pushExpect(0, 16'h0300, 1'b1);
      enCount = 0;
      errSeen = 1'b0;
      for (int c = 0; c < 400 && !errSeen; c++) begin
         @(posedge clk); #1;
         if (err0) begin
            errSeen = 1'b1;
            checkOutput("toEnDrop", dmaEn, 0);
         end else if (dmaEn) begin
            enCount++;
         end
      end
      checkOutput("toErrSeen", errSeen, 1);
      checkOutput("toEnCycles", enCount, 255);
      @(negedge clk) dmaReady = 1'b1;
      waitDrain("timeout", 20);

      // Lock raised during XFER: transfer completes, next grant waits
      applyStimulus(0, 2, 16'h0900, 2'b00, 16'h0000);
      pushExpect(0, 16'h0900, 1'b0);
      pushExpect(0, 16'h0900, 1'b0);
      @(posedge clk); #1;
      checkOutput("lockXferEn", dmaEn, 1);
      checkOutput("lockXferGnt", gnt0, 1);
      @(negedge clk) lock = 1'b1;
      for (int c = 0; c < 6; c++) begin
         @(posedge clk); #1;
         checkOutput("lockHold", dmaEn, 0);
      end
      @(negedge clk) lock = 1'b0;
      waitDrain("lock", 20);

      // Reset mid-XFER: outputs drop at once, no response for the abort
      dmaReady = 1'b0;
      applyStimulus(0, 1, 16'h0500, 2'b00, 16'h0000);
      repeat (3) @(posedge clk);
      @(negedge clk) resetN = 1'b0;
      #1;
      checkOutput("midRstEn", dmaEn, 0);
      checkOutput("midRstBus", {dmaAddr, dmaDin}, 0);
      checkOutput("midRstPulses", {err1, err0, gnt1, gnt0}, 0);
      issued0 = done0;
      @(negedge clk);
      resetN = 1'b1;
      dmaReady = 1'b1;
      applyStimulus(0, 1, 16'h0A00, 2'b00, 16'h0000);
      applyStimulus(1, 1, 16'h0B00, 2'b00, 16'h0000);
      pushExpect(0, 16'h0A00, 1'b0);
      pushExpect(1, 16'h0B00, 1'b0);
      @(posedge clk); #1;
      checkOutput("postRstWin0", {gnt1, gnt0}, 2'b01);
      waitDrain("postRst", 20);

      $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
      $finish;
   end

endmodule
